// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed single-MAC FIR sequencer:
// datapath widths and the sequencer state encoding.
// -----------------------------------------------------------------------------
package fir_pkg;

    // Sample, coefficient and accumulator widths.
    localparam int FIR_DW   = 16;
    localparam int FIR_CW   = 16;
    localparam int FIR_ACCW = 32;

    // Sequencer states. INIT zeroes the sample RAM, IDLE is the only state
    // that accepts work, WRITE stores the new sample, RUN walks the taps,
    // DRAIN absorbs the last RAM read latency, HOLD presents the result.
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        HOLD  = 3'd5
    } fir_state_t;

    // Circular tap address: newest sample sits at wptr, tap k reads k
    // samples back. The subtraction wraps naturally at the address width.
    function automatic logic [7:0] fir_tap_addr(input logic [7:0] wptr,
                                                input logic [7:0] k);
        fir_tap_addr = wptr - k;
    endfunction

endpackage

// File: rtl/fir_mac_acc.sv
// -----------------------------------------------------------------------------
// fir_mac_acc
// Signed 16x16 multiply feeding a 32-bit two's-complement wrapping
// accumulator.
//
// Ports:
//   i_clk   - clock
//   i_rst   - asynchronous active-high reset, clears the accumulator
//   i_clr   - synchronous clear (start of a filter pass)
//   i_en    - add the current product into the accumulator
//   i_smp   - signed sample operand
//   i_coef  - signed coefficient operand
//   o_acc   - accumulator value (registered)
// -----------------------------------------------------------------------------
module fir_mac_acc
    import fir_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_en,
    input  logic signed [FIR_DW-1:0]   i_smp,
    input  logic signed [FIR_CW-1:0]   i_coef,
    output logic signed [FIR_ACCW-1:0] o_acc
);

    logic signed [FIR_ACCW-1:0] w_smp_ext;
    logic signed [FIR_ACCW-1:0] w_coef_ext;
    logic signed [FIR_ACCW-1:0] w_prod;
    logic signed [FIR_ACCW-1:0] r_acc;

    // Sign-extend both operands to the accumulator width; the low 32 bits of
    // the 32x32 product equal the exact signed 16x16 product.
    assign w_smp_ext  = FIR_ACCW'(i_smp);
    assign w_coef_ext = FIR_ACCW'(i_coef);
    assign w_prod     = w_smp_ext * w_coef_ext;

    // Accumulator register: clear has priority, addition wraps modulo 2^32.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= 32'sd0;
        end else if (i_clr) begin
            r_acc <= 32'sd0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
// Sequencer for a single-MAC FIR: accepts a sample, writes it into an external
// circular sample RAM, walks all taps against an external coefficient RAM and
// presents the 32-bit accumulated result. Coefficient writes are only granted
// in IDLE so they never disturb a pass.
//
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      - sample input handshake
//   out_valid/out_ready/out_data   - filter result handshake
//   cfg_we/cfg_ready/cfg_addr/data - coefficient write request
//   smp_we/smp_addr/smp_wdata/rdata- single-port sample RAM (1-cycle read)
//   coef_raddr/coef_rdata          - coefficient RAM read port (1-cycle read)
//   coef_we/coef_waddr/coef_wdata  - coefficient RAM write port
// -----------------------------------------------------------------------------
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int AW    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [FIR_DW-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [FIR_ACCW-1:0] out_data,
    input  logic                       cfg_we,
    output logic                       cfg_ready,
    input  logic [AW-1:0]              cfg_addr,
    input  logic [FIR_CW-1:0]          cfg_data,
    output logic                       smp_we,
    output logic [AW-1:0]              smp_addr,
    output logic [FIR_DW-1:0]          smp_wdata,
    input  logic [FIR_DW-1:0]          smp_rdata,
    output logic [AW-1:0]              coef_raddr,
    input  logic [FIR_CW-1:0]          coef_rdata,
    output logic                       coef_we,
    output logic [AW-1:0]              coef_waddr,
    output logic [FIR_CW-1:0]          coef_wdata
);

    localparam logic [AW-1:0] LAST_K = AW'(NTAPS - 1);

    fir_state_t                 r_state;
    fir_state_t                 w_state_nxt;
    logic [AW-1:0]              r_k;
    logic [AW-1:0]              w_k_nxt;
    logic [AW-1:0]              r_wptr;
    logic [FIR_DW-1:0]          r_sample;
    logic                       r_mac_en;
    logic                       r_out_valid;
    logic                       w_idle;
    logic                       w_accept;
    logic                       w_out_hs;
    logic                       w_last_k;
    logic                       w_mac_clr;
    logic                       w_smp_we;
    logic [AW-1:0]              w_smp_addr;
    logic [FIR_DW-1:0]          w_smp_wdata;
    logic [AW-1:0]              w_coef_raddr;
    logic [AW-1:0]              w_tap_addr;
    logic [7:0]                 w_tap_addr8;
    logic signed [FIR_ACCW-1:0] w_acc;

    assign w_idle    = (r_state == IDLE);
    assign w_last_k  = (r_k == LAST_K);
    // Config wins over a sample in the same cycle, so the sample waits.
    assign w_accept  = w_idle & in_valid & ~cfg_we;
    assign w_out_hs  = (r_state == HOLD) & out_ready;
    assign w_mac_clr = (r_state == WRITE);

    assign w_tap_addr8 = fir_tap_addr(8'(r_wptr), 8'(r_k));
    assign w_tap_addr  = w_tap_addr8[AW-1:0];

    // Next-state and tap/init counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            INIT: begin
                if (w_last_k) begin
                    w_state_nxt = IDLE;
                    w_k_nxt     = {AW{1'b0}};
                end else begin
                    w_state_nxt = INIT;
                    w_k_nxt     = r_k + AW'(1);
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = IDLE;
                end
                w_k_nxt = {AW{1'b0}};
            end
            WRITE: begin
                w_state_nxt = RUN;
                w_k_nxt     = {AW{1'b0}};
            end
            RUN: begin
                if (w_last_k) begin
                    w_state_nxt = DRAIN;
                    w_k_nxt     = {AW{1'b0}};
                end else begin
                    w_state_nxt = RUN;
                    w_k_nxt     = r_k + AW'(1);
                end
            end
            DRAIN: begin
                w_state_nxt = HOLD;
                w_k_nxt     = {AW{1'b0}};
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                end
                w_k_nxt = {AW{1'b0}};
            end
            default: begin
                w_state_nxt = INIT;
                w_k_nxt     = {AW{1'b0}};
            end
        endcase
    end

    // State, counter, write pointer and sample latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_k         <= {AW{1'b0}};
            r_wptr      <= {AW{1'b0}};
            r_sample    <= {FIR_DW{1'b0}};
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            // The slot advances only once the result has been consumed.
            r_wptr      <= w_out_hs ? (r_wptr + AW'(1)) : r_wptr;
            r_sample    <= w_accept ? in_data : r_sample;
            // A tap issued in RUN returns its RAM data one cycle later.
            r_mac_en    <= (r_state == RUN);
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    // RAM address/control generation.
    always_comb begin
        w_smp_we     = 1'b0;
        w_smp_addr   = r_wptr;
        w_smp_wdata  = {FIR_DW{1'b0}};
        w_coef_raddr = {AW{1'b0}};
        case (r_state)
            INIT: begin
                // Gated so the RAM sees no write while reset is held.
                w_smp_we   = ~reset;
                w_smp_addr = r_k;
            end
            WRITE: begin
                w_smp_we    = 1'b1;
                w_smp_addr  = r_wptr;
                w_smp_wdata = r_sample;
            end
            RUN: begin
                w_smp_addr   = w_tap_addr;
                w_coef_raddr = r_k;
            end
            IDLE, DRAIN, HOLD: begin
                w_smp_we = 1'b0;
            end
            default: begin
                w_smp_we = 1'b0;
            end
        endcase
    end

    fir_mac_acc u_mac (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (w_mac_clr),
        .i_en   (r_mac_en),
        .i_smp  (smp_rdata),
        .i_coef (coef_rdata),
        .o_acc  (w_acc)
    );

    assign in_ready   = w_idle & ~cfg_we;
    assign cfg_ready  = w_idle;
    assign coef_we    = cfg_we & w_idle;
    assign coef_waddr = cfg_addr;
    assign coef_wdata = cfg_data;

    assign smp_we     = w_smp_we;
    assign smp_addr   = w_smp_addr;
    assign smp_wdata  = w_smp_wdata;
    assign coef_raddr = w_coef_raddr;

    assign out_valid  = r_out_valid;
    assign out_data   = w_acc;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
// Self-checking bench: external sample/coefficient RAMs are modelled here, and
// expected results come from a plain dot product over the last NTAPS samples.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

    localparam int NTAPS = 8;
    localparam int AW    = 3;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              cfg_we;
    logic              cfg_ready;
    logic [AW-1:0]     cfg_addr;
    logic [15:0]       cfg_data;
    logic              smp_we;
    logic [AW-1:0]     smp_addr;
    logic [15:0]       smp_wdata;
    logic [15:0]       smp_rdata;
    logic [AW-1:0]     coef_raddr;
    logic [15:0]       coef_rdata;
    logic              coef_we;
    logic [AW-1:0]     coef_waddr;
    logic [15:0]       coef_wdata;

    fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .smp_we     (smp_we),
        .smp_addr   (smp_addr),
        .smp_wdata  (smp_wdata),
        .smp_rdata  (smp_rdata),
        .coef_raddr (coef_raddr),
        .coef_rdata (coef_rdata),
        .coef_we    (coef_we),
        .coef_waddr (coef_waddr),
        .coef_wdata (coef_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External RAMs (environment, not the reference model).
    logic [15:0] smp_mem  [NTAPS];
    logic [15:0] coef_mem [NTAPS];
    always @(posedge clk) begin
        if (coef_we) coef_mem[coef_waddr] <= coef_wdata;
        coef_rdata <= coef_mem[coef_raddr];
        if (smp_we) smp_mem[smp_addr] <= smp_wdata;
        else        smp_rdata <= smp_mem[smp_addr];
    end

    // Reference model state: newest sample at index 0.
    logic signed [15:0] m_hist [NTAPS];
    logic signed [15:0] m_coef [NTAPS];
    int                 m_wptr;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < NTAPS; k++) s += longint'(m_hist[k]) * longint'(m_coef[k]);
        return 32'(s);
    endfunction

    // Hold reset, check reset outputs, release and check the INIT sweep.
    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h1234;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check_val("rst_smp_we", 32'(smp_we), 32'd0);
        check_val("rst_coef_we", 32'(coef_we), 32'd0);
        cfg_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NTAPS; i++) m_hist[i] = 16'sd0;
        m_wptr = 0;
        #1;
        for (int i = 0; i < NTAPS; i++) begin
            check_val("init_we", 32'(smp_we), 32'd1);
            check_val("init_addr", 32'(smp_addr), 32'(i));
            check_val("init_wdata", 32'(smp_wdata), 32'd0);
            check_val("init_in_ready", 32'(in_ready), 32'd0);
            check_val("init_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check_val("init_done_in_ready", 32'(in_ready), 32'd1);
        check_val("init_done_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    // Coefficient write issued in IDLE; starts and ends at a negedge.
    task automatic cfg_write(input logic [AW-1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        #1;
        check_val("cfg_coef_we", 32'(coef_we), 32'd1);
        check_val("cfg_waddr", 32'(coef_waddr), 32'(a));
        check_val("cfg_wdata", 32'(coef_wdata), 32'(d));
        check_val("cfg_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        m_coef[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One sample through the filter; starts and ends at a negedge in IDLE.
    task automatic run_sample(input logic [15:0] d, input int bp, input bit cfg_in_run,
                              input int abort_at, output logic [31:0] y_obs,
                              output int wait_n, output int t_acc);
        logic [31:0] y_exp;
        logic [31:0] held;
        int          n;
        bit          seen;
        for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d;
        y_exp = model_out();
        y_obs = 32'd0;
        in_valid = 1'b1; in_data = d; out_ready = (bp == 0);
        #1;
        wait_n = 0;
        while (!in_ready && wait_n < 40) begin
            @(negedge clk); #1; wait_n++;
        end
        check_val("accept_ready", 32'(in_ready), 32'd1);
        t_acc = cyc;
        @(posedge clk);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                check_val("write_we", 32'(smp_we), 32'd1);
                check_val("write_addr", 32'(smp_addr), 32'(m_wptr));
                check_val("write_data", 32'(smp_wdata), 32'(d));
            end
            if (n == 2) check_val("busy_in_ready", 32'(in_ready), 32'd0);
            if (n == 3) begin
                check_val("tap1_smp_addr", 32'(smp_addr), 32'((m_wptr + NTAPS - 1) % NTAPS));
                check_val("tap1_coef_addr", 32'(coef_raddr), 32'd1);
            end
            if (cfg_in_run && n == 4) begin
                cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_data = 16'($urandom);
                #1;
                check_val("run_cfg_ready", 32'(cfg_ready), 32'd0);
                check_val("run_coef_we", 32'(coef_we), 32'd0);
            end
            if (n == 5) cfg_we = 1'b0;
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b1;
                return;
            end
            seen = out_valid;
        end
        check_val("latency", 32'(n), 32'(NTAPS + 3));
        check_val("out_data", out_data, y_exp);
        y_obs = out_data;
        held  = out_data;
        for (int i = 0; i < bp; i++) begin
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_stable", out_data, held);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_cfg_ready", 32'(cfg_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_val("hold_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("done_valid", 32'(out_valid), 32'd0);
        m_wptr = (m_wptr + 1) % NTAPS;
    endtask

    initial begin
        logic [31:0] y;
        logic [15:0] d;
        int          w;
        int          t;
        int          tprev;
        reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0;
        smp_rdata = 16'd0; coef_rdata = 16'd0;
        for (int i = 0; i < NTAPS; i++) begin
            smp_mem[i]  = 16'($urandom);
            coef_mem[i] = 16'd0;
            m_coef[i]   = 16'sd0;
            m_hist[i]   = 16'sd0;
        end
        m_wptr = 0;
        tprev  = 0;
        #2;
        do_reset();

        // Impulse response with coefficients 1..8, back-to-back accepts.
        for (int a = 0; a < NTAPS; a++) cfg_write(3'(a), 16'(a + 1));
        for (int j = 0; j < 10; j++) begin
            run_sample((j == 0) ? 16'h0100 : 16'h0000, 0, 1'b0, 0, y, w, t);
            check_val("impulse", y, (j < NTAPS) ? 32'(256 * (j + 1)) : 32'd0);
            if (j > 0) check_val("period", 32'(t - tprev), 32'(NTAPS + 4));
            tprev = t;
        end

        // Back-pressure, then config attempt during RUN.
        run_sample(16'($urandom), 5, 1'b0, 0, y, w, t);
        run_sample(16'($urandom), 0, 1'b1, 0, y, w, t);

        // Config and sample together in IDLE: config first, sample next cycle.
        d = 16'($urandom);
        in_valid = 1'b1; in_data = d;
        cfg_write(3'($urandom), 16'($urandom));
        run_sample(d, 0, 1'b0, 0, y, w, t);
        check_val("cfg_then_accept", 32'(w), 32'd0);

        // Randomized traffic.
        for (int j = 0; j < 20; j++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(3'($urandom), 16'($urandom));
            run_sample(16'($urandom), int'($urandom_range(0, 2)), 1'b0, 0, y, w, t);
        end

        // Wrap arithmetic.
        for (int a = 0; a < NTAPS; a++) cfg_write(3'(a), 16'h7FFF);
        for (int j = 0; j < NTAPS; j++) run_sample(16'h7FFF, 0, 1'b0, 0, y, w, t);
        check_val("wrap_max", y, 32'hFFF80008);
        do_reset();
        cfg_write(3'd0, 16'd3);
        run_sample(16'hFF00, 0, 1'b0, 0, y, w, t);
        check_val("wrap_neg", y, 32'hFFFFFD00);

        // Reset in the middle of RUN (tap k=4), then a clean impulse.
        run_sample(16'($urandom), 0, 1'b0, 6, y, w, t);
        do_reset();
        run_sample(16'h0100, 0, 1'b0, 0, y, w, t);
        check_val("post_reset_impulse", y, 32'd768);
        run_sample(16'h0000, 0, 1'b0, 0, y, w, t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
